// File: rtl/inta_sequencer.sv
// rtl/inta_sequencer.sv - INTA handshake, ISR and EOI sequencer; INTA_SEQ_AEOI_EN enables automatic EOI
module inta_sequencer #(
    parameter logic [2:0] SPUR_LVL = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [2:0] req_lvl,
    input  logic       isprior,
    input  logic [2:0] lowest_pri,
    input  logic       inta_n,
    input  logic [4:0] vec_base,
    input  logic       aeoi,
    input  logic       eoi_ns,
    input  logic       eoi_sp,
    input  logic [2:0] eoi_lvl,
    output logic       int_o,
    output logic [7:0] isr,
    output logic       irr_clr,
    output logic [2:0] irr_clr_idx,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       eoi_done,
    output logic [2:0] eoi_done_lvl
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PEND  = 3'd1,
        ACK1  = 3'd2,
        WAIT2 = 3'd3,
        ACK2  = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic       inta_q, fall, rise;
    logic [2:0] cur_lvl, cur_lvl_nx;
    logic       spur, spur_nx;
    logic [7:0] isr_set, isr_clr;
    logic       irr_clr_nx;
    logic [2:0] irr_clr_idx_nx;
    logic [7:0] data_out_nx;
    logic       data_oe_nx;
    logic       eoi_done_nx;
    logic [2:0] eoi_done_lvl_nx;
    logic       aeoi_clr;
    logic       aeoi_en;
    logic       ns_hit;
    logic [2:0] ns_lvl, scan_idx;

`ifdef INTA_SEQ_AEOI_EN
    assign aeoi_en = aeoi;
`else
    logic unused_aeoi;
    assign unused_aeoi = aeoi;
    assign aeoi_en     = 1'b0;
`endif

    assign fall  = inta_q & ~inta_n;
    assign rise  = ~inta_q & inta_n;
    assign int_o = (state == PEND);

    always_comb begin
        state_nx       = state;
        cur_lvl_nx     = cur_lvl;
        spur_nx        = spur;
        isr_set        = 8'h00;
        irr_clr_nx     = 1'b0;
        irr_clr_idx_nx = irr_clr_idx;
        data_out_nx    = data_out;
        data_oe_nx     = data_oe;
        aeoi_clr       = 1'b0;
        case (state)
            IDLE: if (req_valid && isprior) state_nx = PEND;
            PEND: if (fall) begin
                state_nx = ACK1;
                if (req_valid) begin
                    cur_lvl_nx        = req_lvl;
                    spur_nx           = 1'b0;
                    isr_set[req_lvl]  = 1'b1;
                    irr_clr_nx        = 1'b1;
                    irr_clr_idx_nx    = req_lvl;
                end else begin
                    cur_lvl_nx = SPUR_LVL;
                    spur_nx    = 1'b1;
                end
            end
            ACK1: if (rise) state_nx = WAIT2;
            WAIT2: if (fall) begin
                state_nx    = ACK2;
                data_oe_nx  = 1'b1;
                data_out_nx = {vec_base, cur_lvl};
            end
            ACK2: if (rise) begin
                state_nx    = IDLE;
                data_oe_nx  = 1'b0;
                data_out_nx = 8'h00;
                aeoi_clr    = aeoi_en & ~spur;
            end
            default: begin
                state_nx    = IDLE;
                data_oe_nx  = 1'b0;
                data_out_nx = 8'h00;
            end
        endcase
    end

    // Non-specific EOI target: first set ISR bit walking up from the rotation base.
    always_comb begin
        ns_hit   = 1'b0;
        ns_lvl   = 3'd0;
        scan_idx = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            scan_idx = lowest_pri + 3'(k);
            if (!ns_hit && isr[scan_idx]) begin
                ns_hit = 1'b1;
                ns_lvl = scan_idx;
            end
        end
    end

    always_comb begin
        isr_clr         = 8'h00;
        eoi_done_nx     = 1'b0;
        eoi_done_lvl_nx = eoi_done_lvl;
        if (eoi_sp) begin
            if (isr[eoi_lvl]) begin
                isr_clr[eoi_lvl] = 1'b1;
                if (!isr_set[eoi_lvl]) begin
                    eoi_done_nx     = 1'b1;
                    eoi_done_lvl_nx = eoi_lvl;
                end
            end
        end else if (eoi_ns && ns_hit) begin
            isr_clr[ns_lvl] = 1'b1;
            if (!isr_set[ns_lvl]) begin
                eoi_done_nx     = 1'b1;
                eoi_done_lvl_nx = ns_lvl;
            end
        end
        if (aeoi_clr && isr[cur_lvl]) begin
            isr_clr[cur_lvl] = 1'b1;
            if (!eoi_done_nx) begin
                eoi_done_nx     = 1'b1;
                eoi_done_lvl_nx = cur_lvl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            inta_q       <= 1'b1;
            isr          <= 8'h00;
            irr_clr      <= 1'b0;
            irr_clr_idx  <= 3'd0;
            data_out     <= 8'h00;
            data_oe      <= 1'b0;
            eoi_done     <= 1'b0;
            eoi_done_lvl <= 3'd0;
            cur_lvl      <= 3'd0;
            spur         <= 1'b0;
        end else begin
            state        <= state_nx;
            inta_q       <= inta_n;
            isr          <= (isr & ~isr_clr) | isr_set;
            irr_clr      <= irr_clr_nx;
            irr_clr_idx  <= irr_clr_idx_nx;
            data_out     <= data_out_nx;
            data_oe      <= data_oe_nx;
            eoi_done     <= eoi_done_nx;
            eoi_done_lvl <= eoi_done_lvl_nx;
            cur_lvl      <= cur_lvl_nx;
            spur         <= spur_nx;
        end
    end
endmodule

// File: tb/tb_inta_sequencer.sv
// tb/tb_inta_sequencer.sv - randomized self-checking bench for inta_sequencer
module tb_inta_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, req_valid, isprior, inta_n, aeoi, eoi_ns, eoi_sp;
    logic [2:0] req_lvl, lowest_pri, eoi_lvl;
    logic [4:0] vec_base;
    logic       int_o, irr_clr, data_oe, eoi_done;
    logic [7:0] isr, data_out;
    logic [2:0] irr_clr_idx, eoi_done_lvl;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] isr_m;

`ifdef INTA_SEQ_AEOI_EN
    localparam bit AEOI_BUILD = 1'b1;
`else
    localparam bit AEOI_BUILD = 1'b0;
`endif

    inta_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lvl(req_lvl),
        .isprior(isprior), .lowest_pri(lowest_pri), .inta_n(inta_n),
        .vec_base(vec_base), .aeoi(aeoi), .eoi_ns(eoi_ns), .eoi_sp(eoi_sp),
        .eoi_lvl(eoi_lvl), .int_o(int_o), .isr(isr), .irr_clr(irr_clr),
        .irr_clr_idx(irr_clr_idx), .data_out(data_out), .data_oe(data_oe),
        .eoi_done(eoi_done), .eoi_done_lvl(eoi_done_lvl)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = 1'b0; isprior = 1'b0; inta_n = 1'b1; aeoi = 1'b0;
        eoi_ns = 1'b0; eoi_sp = 1'b0; req_lvl = 3'd0; lowest_pri = 3'd7; eoi_lvl = 3'd0;
        vec_base = 5'h00;
        tick(); tick();
        rst_n = 1'b1;
        isr_m = 8'h00;
        tick();
    endtask

    // Full two-pulse acknowledge, checked against the bench's ISR model.
    task automatic do_ack(input logic [2:0] lvl, input logic [4:0] vb, input bit spurious,
                          input bit use_aeoi, input bit collide, input bit keep_req);
        logic [7:0] exp_vec;
        bit         exp_done;
        aeoi = use_aeoi; req_valid = 1'b1; isprior = 1'b1; req_lvl = lvl; vec_base = vb;
        tick();
        vectors++; if (int_o !== 1'b1) begin miscompares++; $display("FAIL int_o_raise: got %0b want 1", int_o); end
        if (spurious) req_valid = 1'b0;
        inta_n = 1'b0;
        if (collide) begin eoi_sp = 1'b1; eoi_lvl = lvl; end
        tick();
        eoi_sp = 1'b0;
        if (!spurious) isr_m[lvl] = 1'b1;
        vectors++; if (int_o !== 1'b0) begin miscompares++; $display("FAIL int_o_drop: got %0b want 0", int_o); end
        vectors++; if (isr !== isr_m) begin miscompares++; $display("FAIL isr_set: got %h want %h", isr, isr_m); end
        vectors++; if (irr_clr !== !spurious) begin miscompares++; $display("FAIL irr_clr: got %0b want %0b", irr_clr, !spurious); end
        if (!spurious) begin
            vectors++; if (irr_clr_idx !== lvl) begin miscompares++; $display("FAIL irr_clr_idx: got %0d want %0d", irr_clr_idx, lvl); end
        end
        if (collide) begin
            vectors++; if (eoi_done !== 1'b0) begin miscompares++; $display("FAIL collide_eoi_done: got %0b want 0", eoi_done); end
        end
        req_valid = keep_req; isprior = keep_req;
        tick();
        vectors++; if (irr_clr !== 1'b0) begin miscompares++; $display("FAIL irr_clr_pulse: got %0b want 0", irr_clr); end
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        exp_vec = {vb, spurious ? 3'd7 : lvl};
        vectors++; if (data_oe !== 1'b1) begin miscompares++; $display("FAIL data_oe_on: got %0b want 1", data_oe); end
        vectors++; if (data_out !== exp_vec) begin miscompares++; $display("FAIL vector: got %h want %h", data_out, exp_vec); end
        tick();
        inta_n = 1'b1; tick();
        exp_done = AEOI_BUILD && use_aeoi && !spurious && isr_m[lvl];
        if (exp_done) isr_m[lvl] = 1'b0;
        vectors++; if (data_oe !== 1'b0) begin miscompares++; $display("FAIL data_oe_off: got %0b want 0", data_oe); end
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL data_out_idle: got %h want 00", data_out); end
        vectors++; if (isr !== isr_m) begin miscompares++; $display("FAIL isr_after_ack: got %h want %h", isr, isr_m); end
        vectors++; if (eoi_done !== exp_done) begin miscompares++; $display("FAIL aeoi_done: got %0b want %0b", eoi_done, exp_done); end
        if (exp_done) begin
            vectors++; if (eoi_done_lvl !== lvl) begin miscompares++; $display("FAIL aeoi_lvl: got %0d want %0d", eoi_done_lvl, lvl); end
        end
        aeoi = 1'b0;
    endtask

    task automatic do_eoi(input bit ns, input bit sp, input logic [2:0] lvl, input logic [2:0] lp);
        bit         exp_done = 1'b0;
        logic [2:0] exp_lvl = 3'd0;
        logic [2:0] idx;
        if (sp) begin
            if (isr_m[lvl]) begin exp_done = 1'b1; exp_lvl = lvl; end
        end else if (ns) begin
            for (int k = 1; k <= 8; k++) begin
                idx = 3'((int'(lp) + k) % 8);
                if (!exp_done && isr_m[idx]) begin exp_done = 1'b1; exp_lvl = idx; end
            end
        end
        if (exp_done) isr_m[exp_lvl] = 1'b0;
        eoi_ns = ns; eoi_sp = sp; eoi_lvl = lvl; lowest_pri = lp;
        tick();
        eoi_ns = 1'b0; eoi_sp = 1'b0;
        vectors++; if (eoi_done !== exp_done) begin miscompares++; $display("FAIL eoi_done: got %0b want %0b", eoi_done, exp_done); end
        if (exp_done) begin
            vectors++; if (eoi_done_lvl !== exp_lvl) begin miscompares++; $display("FAIL eoi_done_lvl: got %0d want %0d", eoi_done_lvl, exp_lvl); end
        end
        vectors++; if (isr !== isr_m) begin miscompares++; $display("FAIL isr_after_eoi: got %h want %h", isr, isr_m); end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (int_o !== 1'b0) begin miscompares++; $display("FAIL rst_int_o: got %0b want 0", int_o); end
        vectors++; if (isr !== 8'h00) begin miscompares++; $display("FAIL rst_isr: got %h want 00", isr); end
        vectors++; if (data_oe !== 1'b0 || data_out !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %0b/%h want 0/00", data_oe, data_out); end
        vectors++; if (irr_clr !== 1'b0 || irr_clr_idx !== 3'd0) begin miscompares++; $display("FAIL rst_irr: got %0b/%0d want 0/0", irr_clr, irr_clr_idx); end
        vectors++; if (eoi_done !== 1'b0 || eoi_done_lvl !== 3'd0) begin miscompares++; $display("FAIL rst_eoi: got %0b/%0d want 0/0", eoi_done, eoi_done_lvl); end
    endtask

    task automatic test_basic_ack();
        do_reset();
        do_ack(3'd3, 5'h08, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++; if (isr !== 8'h08) begin miscompares++; $display("FAIL basic_isr: got %h want 08", isr); end
    endtask

    task automatic test_spurious();
        do_reset();
        do_ack(3'd5, 5'h1b, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_eoi();
        do_reset();
        do_ack(3'd7, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        do_ack(3'd0, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        do_eoi(1'b1, 1'b0, 3'd0, 3'd6);
        vectors++; if (isr !== 8'h01 || eoi_done_lvl !== 3'd7) begin miscompares++; $display("FAIL wrap_eoi: got %h/%0d want 01/7", isr, eoi_done_lvl); end
        do_eoi(1'b1, 1'b1, 3'd3, 3'd6);
    endtask

    task automatic test_aeoi();
        do_reset();
        do_ack(3'd2, 5'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_collide();
        do_reset();
        do_ack(3'd4, 5'h05, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        do_ack(3'd1, 5'h0c, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++; if (int_o !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %0b want 0", int_o); end
        tick();
        vectors++; if (int_o !== 1'b1) begin miscompares++; $display("FAIL b2b_reassert: got %0b want 1", int_o); end
        do_ack(3'd6, 5'h0c, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 1'b1; isprior = 1'b1; req_lvl = 3'd5; vec_base = 5'h11;
        tick();
        req_valid = 1'b0; isprior = 1'b0; inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        vectors++; if (data_oe !== 1'b1) begin miscompares++; $display("FAIL mid_data_oe_on: got %0b want 1", data_oe); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (data_oe !== 1'b0 || isr !== 8'h00 || data_out !== 8'h00) begin miscompares++; $display("FAIL mid_reset: got %0b/%h/%h want 0/00/00", data_oe, isr, data_out); end
        tick();
        rst_n = 1'b1; inta_n = 1'b1; isr_m = 8'h00;
        tick();
        vectors++; if (int_o !== 1'b0 || isr !== 8'h00) begin miscompares++; $display("FAIL mid_idle: got %0b/%h want 0/00", int_o, isr); end
        do_ack(3'd2, 5'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_ack(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                       $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else begin
                do_eoi(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_ack();
        test_spurious();
        test_wrap_eoi();
        test_aeoi();
        test_collide();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 Parameter: SPUR_LVL, 7, level index returned in the vector for a spurious acknowledge.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  resolver has an unmasked pending request.
REQ-005 req_lvl  input  3  highest-priority pending level from resolver.
REQ-006 isprior  input  1  resolver flag: req_lvl outranks every in-service level.
REQ-007 lowest_pri  input  3  current lowest-priority level (rotation base) from resolver.
REQ-008 inta_n  input  1  CPU acknowledge strobe, active-low, synchronous to clk.
REQ-009 vec_base  input  5  ICW2 bits T7..T3.
REQ-010 aeoi  input  1  automatic-EOI mode select.
REQ-011 eoi_ns  input  1  non-specific EOI command pulse, one cycle.
REQ-012 eoi_sp  input  1  specific EOI command pulse, one cycle.
REQ-013 eoi_lvl  input  3  level targeted by eoi_sp.
REQ-014 int_o  output  1  interrupt request to CPU.
REQ-015 isr  output  8  in-service register, fed back to resolver.
REQ-016 irr_clr  output  1  one-cycle pulse clearing IRR bit irr_clr_idx.
REQ-017 irr_clr_idx  output  3  IRR bit to clear.
REQ-018 data_out  output  8  interrupt vector.
REQ-019 data_oe  output  1  data_out drive enable.
REQ-020 eoi_done  output  1  one-cycle pulse when an EOI clears an ISR bit; eoi_done_lvl carries that level.
REQ-021 eoi_done_lvl  output  3  level cleared (resolver uses it for rotate-on-EOI).

Function
REQ-022 Edge detect: register inta_q of inta_n; fall = inta_q & ~inta_n, rise = ~inta_q & inta_n.
REQ-023 States: IDLE, PEND, ACK1, WAIT2, ACK2; encoded in 3 bits; unused codes return to IDLE.
REQ-024 IDLE: req_valid & isprior -> PEND, int_o = 1 from the next cycle (1-cycle latency).
REQ-025 PEND, fall with req_valid = 1: latch cur_lvl = req_lvl, set isr[cur_lvl], irr_clr pulse with irr_clr_idx = cur_lvl, int_o = 0, -> ACK1.
REQ-026 PEND, fall with req_valid = 0 (spurious): cur_lvl = SPUR_LVL, spur flag = 1, no ISR set, no irr_clr, int_o = 0, -> ACK1.
REQ-027 PEND: int_o stays 1 even if req_valid drops; only INTA or reset ends PEND.
REQ-028 ACK1 rise -> WAIT2; WAIT2 fall -> ACK2 with data_out = {vec_base, cur_lvl}, data_oe = 1 from the next cycle.
REQ-029 ACK2 rise: data_oe = 0 next cycle; if aeoi = 1 and spur = 0, clear isr[cur_lvl] and pulse eoi_done; -> IDLE.
REQ-030 data_out holds 8'h00 whenever data_oe = 0.
REQ-031 Non-specific EOI: clear the highest-priority set ISR bit, scanned from (lowest_pri+1) mod 8 upward with wrap-around; no bit set -> no action, no eoi_done.
REQ-032 Specific EOI: clear isr[eoi_lvl]; bit already clear -> no eoi_done.
REQ-033 eoi_ns and eoi_sp in the same cycle: eoi_sp wins.
REQ-034 EOI clear and ISR set of the same bit in the same cycle: set wins; different bits: both apply.
REQ-035 Back-to-back: returning to IDLE with a qualifying request re-asserts int_o on the following cycle.

Reset
REQ-036 rst_n low: state = IDLE, inta_q = 1, isr = 8'h00, int_o = 0, irr_clr = 0, irr_clr_idx = 0, data_out = 8'h00, data_oe = 0, eoi_done = 0, eoi_done_lvl = 0, cur_lvl = 0, spur = 0; applies mid-sequence and drops data_oe immediately.

Configuration
REQ-037 Macro INTA_SEQ_AEOI_EN defined: aeoi behaves per REQ-029.
REQ-038 Macro INTA_SEQ_AEOI_EN undefined: aeoi input ignored; ISR bits clear only via EOI commands.

Verification
REQ-039 req_lvl = 3, isprior = 1, vec_base = 5'h08, two INTA pulses -> int_o high, isr = 8'h08, irr_clr_idx = 3, data_out = 8'h43 during the second pulse.
REQ-040 int_o high, req_valid dropped before the first INTA -> data_out = {vec_base, 3'd7}, isr unchanged, no irr_clr.
REQ-041 isr = 8'h81, lowest_pri = 6, eoi_ns -> isr = 8'h01, eoi_done_lvl = 7 (wrap-around scan).
REQ-042 aeoi = 1, macro defined, level 2 acknowledged -> isr returns to 8'h00 after the second INTA rise, eoi_done_lvl = 2; macro undefined -> isr stays 8'h04.
REQ-043 rst_n pulsed low while in ACK2 -> data_oe = 0 and isr = 8'h00 in the same cycle, state IDLE.
REQ-044 eoi_sp with eoi_lvl = 4 in the same cycle as an ISR set of level 4 -> isr[4] = 1, no eoi_done.
